// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and line-level constants.
// Used by uart_tx now; the receiver will move onto it later.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Even parity: the extra bit makes the total count of ones even.
  function automatic logic uartEvenParity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: a wrapping down-counter that pulses bit_end on the last
// clk cycle of every CLKS_PER_BIT-cycle bit slot while enabled.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] clkCnt;

  // A slot runs 0, LAST, LAST-1, ..., 1, so the count rests at 0 between slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clkCnt <= '0;
    end else if (clear) begin
      clkCnt <= '0;
    end else if (enable) begin
      if (clkCnt == '0) begin
        clkCnt <= LAST;
      end else begin
        clkCnt <= clkCnt - 1'b1;
      end
    end
  end

  assign bit_end = enable && !clear && (clkCnt == CW'(1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, idle-high line with start/busy/done handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 out,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t          state;
  logic [DATA_BITS-1:0] shiftReg;
  logic [2:0]           bitIdx;
  logic                 bitEnd;
  logic                 timerClear;
  logic                 timerEnable;
`ifdef UART_TX_PARITY_EN
  logic                 parityBit;
`endif

  // The timer is held at zero whenever no frame is on the line, so every
  // frame starts with a full-length start bit.
  assign timerClear  = !en || (state == IDLE);
  assign timerEnable = (state != IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) bitTimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timerClear),
    .enable  (timerEnable),
    .bit_end (bitEnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      out      <= UART_IDLE_LEVEL;
      busy     <= 1'b0;
      done     <= 1'b0;
      shiftReg <= '0;
      bitIdx   <= '0;
`ifdef UART_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else if (!en) begin
      state    <= IDLE;
      out      <= UART_IDLE_LEVEL;
      busy     <= 1'b0;
      done     <= 1'b0;
      shiftReg <= '0;
      bitIdx   <= '0;
`ifdef UART_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          out  <= UART_IDLE_LEVEL;
          busy <= 1'b0;
          if (start) begin
            shiftReg <= data;
            bitIdx   <= '0;
`ifdef UART_TX_PARITY_EN
            parityBit <= uartEvenParity(data);
`endif
            state    <= START;
            out      <= ~UART_IDLE_LEVEL;
            busy     <= 1'b1;
          end
        end

        START: begin
          if (bitEnd) begin
            state <= DATA;
            out   <= shiftReg[0];
          end
        end

        // Next bit is presented from shiftReg[1] in the same edge that shifts.
        DATA: begin
          if (bitEnd) begin
            shiftReg <= shiftReg >> 1;
            bitIdx   <= bitIdx + 3'd1;
            if (bitIdx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              out   <= parityBit;
`else
              state <= STOP;
              out   <= UART_IDLE_LEVEL;
`endif
            end else begin
              out <= shiftReg[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bitEnd) begin
            state <= STOP;
            out   <= UART_IDLE_LEVEL;
          end
        end
`endif

        STOP: begin
          if (bitEnd) begin
            state <= IDLE;
            out   <= UART_IDLE_LEVEL;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          out      <= UART_IDLE_LEVEL;
          busy     <= 1'b0;
          shiftReg <= '0;
          bitIdx   <= '0;
        end
      endcase
    end
  end

endmodule
